// File: rtl/mem_access_sequencer_if.sv
// Request/response and datapath-strobe bundle between the control unit,
// the memory access sequencer, and the MAR/MDR/RAM datapath.
interface mem_access_sequencer_if;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned LSB_W   = 3;
    localparam int unsigned FAULT_W = 2;

    // Request side (control unit -> sequencer) and RAM handshake
    logic                 req;
    logic [OP_W-1:0]      req_op;
    logic [LSB_W-1:0]     addr_lsb;
    logic                 MFC;

    // Status back to the control unit
    logic                 busy;
    logic                 done;
    logic [FAULT_W-1:0]   fault;

    // Datapath strobes
    logic                 MAR_Enable;
    logic                 addr_inc;
    logic                 MDR_Enable;
    logic                 MDR_Mux_select;
    logic                 RAM_enable;
    logic [OP_W-1:0]      RAM_OpCode;
    logic                 word_sel;
    logic                 temp_enable;
    logic                 rf_write;

    modport master (
        output req, req_op, addr_lsb, MFC,
        input  busy, done, fault,
        input  MAR_Enable, addr_inc, MDR_Enable, MDR_Mux_select,
        input  RAM_enable, RAM_OpCode, word_sel, temp_enable, rf_write
    );

    modport slave (
        input  req, req_op, addr_lsb, MFC,
        output busy, done, fault,
        output MAR_Enable, addr_inc, MDR_Enable, MDR_Mux_select,
        output RAM_enable, RAM_OpCode, word_sel, temp_enable, rf_write
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// Steps one SPARC V8 load/store/doubleword/SWAP through MAR, RAM (MFC handshake),
// MDR and register-file write-back; reports alignment, illegal-op and timeout faults.
module mem_access_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                  Clk,
    input  logic                  RESET,
    mem_access_sequencer_if.slave bus
);
    localparam int unsigned OP_W    = 6;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned FAULT_W = 2;

    localparam logic [OP_W-1:0] OP_LD   = 6'b000000;
    localparam logic [OP_W-1:0] OP_LDUB = 6'b000001;
    localparam logic [OP_W-1:0] OP_LDUH = 6'b000010;
    localparam logic [OP_W-1:0] OP_LDD  = 6'b000011;
    localparam logic [OP_W-1:0] OP_ST   = 6'b000100;
    localparam logic [OP_W-1:0] OP_STB  = 6'b000101;
    localparam logic [OP_W-1:0] OP_STH  = 6'b000110;
    localparam logic [OP_W-1:0] OP_STD  = 6'b000111;
    localparam logic [OP_W-1:0] OP_LDSB = 6'b001001;
    localparam logic [OP_W-1:0] OP_LDSH = 6'b001010;
    localparam logic [OP_W-1:0] OP_SWAP = 6'b001111;

    localparam logic [FAULT_W-1:0] FLT_NONE    = 2'b00;
    localparam logic [FAULT_W-1:0] FLT_ALIGN   = 2'b01;
    localparam logic [FAULT_W-1:0] FLT_TIMEOUT = 2'b10;
    localparam logic [FAULT_W-1:0] FLT_ILLEGAL = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_MAR,
        S_RD_WAIT,
        S_RD_MDR,
        S_TEMP,
        S_WR_MDR,
        S_WR_WAIT,
        S_WB,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [OP_W-1:0]    r_op;
    logic               r_word_sel;
    logic [CNT_W-1:0]   r_cnt;

    logic               r_busy;
    logic               r_done;
    logic [FAULT_W-1:0] r_fault;
    logic               r_mar_en;
    logic               r_addr_inc;
    logic               r_mdr_en;
    logic               r_mdr_sel;
    logic               r_ram_en;
    logic [OP_W-1:0]    r_ram_op;
    logic               r_temp_en;
    logic               r_rf_write;

    state_t             w_nxt_state;
    logic [OP_W-1:0]    w_nxt_op;
    logic               w_nxt_word_sel;
    logic [CNT_W-1:0]   w_nxt_cnt;
    logic [FAULT_W-1:0] w_nxt_fault;

    function automatic logic f_legal(input logic [OP_W-1:0] op);
        case (op)
            OP_LD, OP_LDUB, OP_LDUH, OP_LDSB, OP_LDSH, OP_LDD,
            OP_ST, OP_STB, OP_STH, OP_STD, OP_SWAP: f_legal = 1'b1;
            default:                                f_legal = 1'b0;
        endcase
    endfunction

    function automatic logic f_misaligned(input logic [OP_W-1:0] op, input logic [2:0] lsb);
        case (op)
            OP_LD, OP_ST, OP_SWAP:    f_misaligned = (lsb[1:0] != 2'b00);
            OP_LDUH, OP_LDSH, OP_STH: f_misaligned = lsb[0];
            OP_LDD, OP_STD:           f_misaligned = (lsb != 3'b000);
            default:                  f_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic f_is_store(input logic [OP_W-1:0] op);
        f_is_store = (op == OP_ST) || (op == OP_STB) || (op == OP_STH) || (op == OP_STD);
    endfunction

    // Doubleword and SWAP present plain LD/ST opcodes; everything else passes op3 through
    function automatic logic [OP_W-1:0] f_ram_op(input state_t st, input logic [OP_W-1:0] op);
        f_ram_op = OP_LD;
        if (st == S_RD_WAIT) begin
            f_ram_op = ((op == OP_SWAP) || (op == OP_LDD)) ? OP_LD : op;
        end else if (st == S_WR_WAIT) begin
            f_ram_op = ((op == OP_SWAP) || (op == OP_STD)) ? OP_ST : op;
        end
    endfunction

    // Next-state decode; MFC takes priority over the timeout check in wait states
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_op       = r_op;
        w_nxt_word_sel = r_word_sel;
        w_nxt_cnt      = r_cnt;
        w_nxt_fault    = FLT_NONE;
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    w_nxt_op       = bus.req_op;
                    w_nxt_word_sel = 1'b0;
                    if (!f_legal(bus.req_op)) begin
                        w_nxt_state = S_DONE;
                        w_nxt_fault = FLT_ILLEGAL;
                    end else if (f_misaligned(bus.req_op, bus.addr_lsb)) begin
                        w_nxt_state = S_DONE;
                        w_nxt_fault = FLT_ALIGN;
                    end else begin
                        w_nxt_state = S_MAR;
                    end
                end
            end
            S_MAR: begin
                w_nxt_state = f_is_store(r_op) ? S_WR_MDR : S_RD_WAIT;
                w_nxt_cnt   = '0;
            end
            S_RD_WAIT: begin
                if (bus.MFC) begin
                    w_nxt_state = S_RD_MDR;
                end else if (r_cnt == CNT_LAST) begin
                    w_nxt_state = S_DONE;
                    w_nxt_fault = FLT_TIMEOUT;
                end else begin
                    w_nxt_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_RD_MDR: begin
                w_nxt_state = (r_op == OP_SWAP) ? S_TEMP : S_WB;
            end
            S_TEMP: begin
                w_nxt_state = S_WR_MDR;
            end
            S_WR_MDR: begin
                w_nxt_state = S_WR_WAIT;
                w_nxt_cnt   = '0;
            end
            S_WR_WAIT: begin
                if (bus.MFC) begin
                    if (r_op == OP_SWAP) begin
                        w_nxt_state = S_WB;
                    end else if ((r_op == OP_STD) && !r_word_sel) begin
                        w_nxt_state    = S_MAR;
                        w_nxt_word_sel = 1'b1;
                    end else begin
                        w_nxt_state = S_DONE;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_nxt_state = S_DONE;
                    w_nxt_fault = FLT_TIMEOUT;
                end else begin
                    w_nxt_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_WB: begin
                if ((r_op == OP_LDD) && !r_word_sel) begin
                    w_nxt_state    = S_MAR;
                    w_nxt_word_sel = 1'b1;
                end else begin
                    w_nxt_state = S_DONE;
                end
            end
            S_DONE: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    // State plus Moore outputs registered from the next state, so they line up with r_state
    always_ff @(posedge Clk) begin
        if (!RESET) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_word_sel <= 1'b0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fault    <= FLT_NONE;
            r_mar_en   <= 1'b0;
            r_addr_inc <= 1'b0;
            r_mdr_en   <= 1'b0;
            r_mdr_sel  <= 1'b0;
            r_ram_en   <= 1'b0;
            r_ram_op   <= '0;
            r_temp_en  <= 1'b0;
            r_rf_write <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_op       <= w_nxt_op;
            r_word_sel <= w_nxt_word_sel;
            r_cnt      <= w_nxt_cnt;
            r_busy     <= (w_nxt_state != S_IDLE);
            r_done     <= (w_nxt_state == S_DONE);
            r_fault    <= (w_nxt_state == S_DONE) ? w_nxt_fault : FLT_NONE;
            r_mar_en   <= (w_nxt_state == S_MAR);
            r_addr_inc <= (w_nxt_state == S_MAR) && w_nxt_word_sel;
            r_mdr_en   <= (w_nxt_state == S_RD_MDR) || (w_nxt_state == S_WR_MDR);
            r_mdr_sel  <= (w_nxt_state == S_RD_WAIT) || (w_nxt_state == S_RD_MDR);
            r_ram_en   <= (w_nxt_state == S_RD_WAIT) || (w_nxt_state == S_WR_WAIT);
            r_ram_op   <= f_ram_op(w_nxt_state, w_nxt_op);
            r_temp_en  <= (w_nxt_state == S_TEMP);
            r_rf_write <= (w_nxt_state == S_WB);
        end
    end

    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.fault          = r_fault;
    assign bus.MAR_Enable     = r_mar_en;
    assign bus.addr_inc       = r_addr_inc;
    assign bus.MDR_Enable     = r_mdr_en;
    assign bus.MDR_Mux_select = r_mdr_sel;
    assign bus.RAM_enable     = r_ram_en;
    assign bus.RAM_OpCode     = r_ram_op;
    assign bus.word_sel       = r_word_sel;
    assign bus.temp_enable    = r_temp_en;
    assign bus.rf_write       = r_rf_write;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Vector table plus scoreboard for mem_access_sequencer; hand sequences cover
// reset mid-operation, req while busy and back-to-back requests.
module tb_mem_access_sequencer;
    logic Clk;
    logic RESET;

    mem_access_sequencer_if bus ();

    mem_access_sequencer #(.TIMEOUT_CYCLES(15)) dut (
        .Clk   (Clk),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [2:0] lsb;
        int         d;          // wait cycles with MFC low before raising it
        int         done_cyc;
        int         fault;
        int         ram;
        int         mar;
        int         inc;
        int         rfw;
        int         rfw_cyc;
        int         ws;         // word_sel seen at rf_write #0 (bit0) and #1 (bit1)
        int         tmp;
        int         mdr_rd;
        int         mdr_wr;
        int         rd_opc;
        int         wr_opc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [17:0] w_all;
    assign w_all = {bus.busy, bus.done, bus.fault, bus.MAR_Enable, bus.addr_inc,
                    bus.MDR_Enable, bus.MDR_Mux_select, bus.RAM_enable, bus.RAM_OpCode,
                    bus.word_sel, bus.temp_enable, bus.rf_write};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [5:0] op, input logic [2:0] lsb,
                           input int d, input int done_cyc, input int fault, input int ram,
                           input int mar, input int inc, input int rfw, input int rfw_cyc,
                           input int ws, input int tmp, input int mdr_rd, input int mdr_wr,
                           input int rd_opc, input int wr_opc);
        vec_t v;
        v.name = name; v.op = op; v.lsb = lsb; v.d = d; v.done_cyc = done_cyc;
        v.fault = fault; v.ram = ram; v.mar = mar; v.inc = inc; v.rfw = rfw;
        v.rfw_cyc = rfw_cyc; v.ws = ws; v.tmp = tmp; v.mdr_rd = mdr_rd;
        v.mdr_wr = mdr_wr; v.rd_opc = rd_opc; v.wr_opc = wr_opc;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc, wcnt, ram, mar, inc, rfw, rfw_cyc, ws, tmp, mdr_rd, mdr_wr;
        int   rd_opc, wr_opc, quiet_bad, got_fault;
        bit   seen;
        vec_t e;
        cyc = 1; wcnt = 0; ram = 0; mar = 0; inc = 0; rfw = 0; rfw_cyc = 0; ws = 0;
        tmp = 0; mdr_rd = 0; mdr_wr = 0; rd_opc = 0; wr_opc = 0; quiet_bad = 0;
        got_fault = -1; seen = 1'b0;
        sb_q.push_back(v);
        @(negedge Clk);
        bus.req = 1'b1; bus.req_op = v.op; bus.addr_lsb = v.lsb; bus.MFC = 1'b0;
        @(negedge Clk);
        bus.req = 1'b0; bus.req_op = 6'b0; bus.addr_lsb = 3'b0;
        while (!seen && cyc < 300) begin
            if (bus.RAM_enable) begin
                ram++;
                if (bus.MDR_Mux_select) rd_opc = int'(bus.RAM_OpCode);
                else                    wr_opc = int'(bus.RAM_OpCode);
            end else if (bus.RAM_OpCode != 6'b0) begin
                quiet_bad++;
            end
            if (bus.MAR_Enable) mar++;
            if (bus.addr_inc) begin
                inc++;
                if (!bus.MAR_Enable) quiet_bad++;
            end
            if (bus.MDR_Enable) begin
                if (bus.MDR_Mux_select) mdr_rd++;
                else                    mdr_wr++;
            end
            if (bus.temp_enable) tmp++;
            if (bus.rf_write) begin
                if (rfw == 0) rfw_cyc = cyc;
                if (rfw < 2) ws = ws | (int'(bus.word_sel) << rfw);
                rfw++;
            end
            if (bus.done) begin
                seen = 1'b1;
                got_fault = int'(bus.fault);
                bus.MFC = 1'b0;
            end else begin
                bus.MFC = bus.RAM_enable && (wcnt >= v.d);
                wcnt = bus.RAM_enable ? wcnt + 1 : 0;
                @(negedge Clk);
                cyc++;
            end
        end
        e = sb_q.pop_front();
        if (!seen) begin
            chk({e.name, ".done_seen"}, 0, 1);
        end else begin
            chk({e.name, ".done_cyc"}, cyc, e.done_cyc);
            chk({e.name, ".fault"}, got_fault, e.fault);
            chk({e.name, ".ram_cycles"}, ram, e.ram);
            chk({e.name, ".mar"}, mar, e.mar);
            chk({e.name, ".addr_inc"}, inc, e.inc);
            chk({e.name, ".rf_write"}, rfw, e.rfw);
            chk({e.name, ".rf_write_cyc"}, rfw_cyc, e.rfw_cyc);
            chk({e.name, ".word_sel"}, ws, e.ws);
            chk({e.name, ".temp"}, tmp, e.tmp);
            chk({e.name, ".mdr_rd"}, mdr_rd, e.mdr_rd);
            chk({e.name, ".mdr_wr"}, mdr_wr, e.mdr_wr);
            chk({e.name, ".rd_opcode"}, rd_opc, e.rd_opc);
            chk({e.name, ".wr_opcode"}, wr_opc, e.wr_opc);
            chk({e.name, ".quiet_strobes"}, quiet_bad, 0);
        end
        @(negedge Clk);
        chk({e.name, ".busy_after"}, int'(bus.busy), 0);
        chk({e.name, ".done_after"}, int'(bus.done), 0);
    endtask

    initial begin
        int n_done, first_done, second_done, fault_at_done, done_cyc;

        //       name        op         lsb     d   done flt ram mar inc rfw rcyc ws tmp mrd mwr rd_opc wr_opc
        add_vec("ld_wait2",  6'b000000, 3'b000, 2,   7,  0,  3,  1,  0,  1,  6,  0,  0,  1,  0,  0,  0);
        add_vec("ldd",       6'b000011, 3'b000, 0,   9,  0,  2,  2,  1,  2,  4,  2,  0,  2,  0,  0,  0);
        add_vec("swap",      6'b001111, 3'b000, 0,   8,  0,  2,  1,  0,  1,  7,  0,  1,  1,  1,  0,  4);
        add_vec("sth_mis",   6'b000110, 3'b001, 0,   1,  1,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0);
        add_vec("ldd_mis",   6'b000011, 3'b100, 0,   1,  1,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0);
        add_vec("ill_3f",    6'b111111, 3'b000, 0,   1,  3,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0);
        add_vec("st_tmo",    6'b000100, 3'b000, 255, 18, 2, 15,  1,  0,  0,  0,  0,  0,  0,  1,  0,  4);
        add_vec("st",        6'b000100, 3'b000, 0,   4,  0,  1,  1,  0,  0,  0,  0,  0,  0,  1,  0,  4);
        add_vec("std",       6'b000111, 3'b000, 0,   7,  0,  2,  2,  1,  0,  0,  0,  0,  0,  2,  0,  4);
        add_vec("ldub_b3",   6'b000001, 3'b011, 1,   6,  0,  2,  1,  0,  1,  5,  0,  0,  1,  0,  1,  0);
        add_vec("ldsh",      6'b001010, 3'b010, 0,   5,  0,  1,  1,  0,  1,  4,  0,  0,  1,  0, 10,  0);
        add_vec("stb_w3",    6'b000101, 3'b111, 3,   7,  0,  4,  1,  0,  0,  0,  0,  0,  0,  1,  0,  5);
        add_vec("ld_mis",    6'b000000, 3'b010, 0,   1,  1,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0);
        add_vec("ldsb_b5",   6'b001001, 3'b101, 0,   5,  0,  1,  1,  0,  1,  4,  0,  0,  1,  0,  9,  0);
        add_vec("swap_tmo",  6'b001111, 3'b000, 255, 17, 2, 15,  1,  0,  0,  0,  0,  0,  0,  0,  0,  0);
        add_vec("ill_08",    6'b001000, 3'b000, 0,   1,  3,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0);

        bus.req = 1'b0; bus.req_op = 6'b0; bus.addr_lsb = 3'b0; bus.MFC = 1'b0;
        RESET = 1'b0;
        repeat (2) @(negedge Clk);
        chk("reset_outputs", int'(w_all), 0);
        RESET = 1'b1;
        // MFC while idle must not start anything
        bus.MFC = 1'b1;
        @(negedge Clk);
        chk("idle_mfc_busy", int'(bus.busy), 0);
        bus.MFC = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset arriving during RD_WAIT of an LD
        @(negedge Clk);
        bus.req = 1'b1; bus.req_op = 6'b000000; bus.addr_lsb = 3'b000; bus.MFC = 1'b0;
        @(negedge Clk);
        bus.req = 1'b0;
        @(negedge Clk);
        chk("rst_mid.in_wait", int'(bus.RAM_enable), 1);
        RESET = 1'b0;
        @(negedge Clk);
        chk("rst_mid.outputs", int'(w_all), 0);
        RESET = 1'b1;
        bus.MFC = 1'b1;
        n_done = 0;
        repeat (20) begin
            @(negedge Clk);
            if (bus.done) n_done++;
        end
        chk("rst_mid.no_done", n_done, 0);
        bus.MFC = 1'b0;

        // req while busy is ignored
        @(negedge Clk);
        bus.req = 1'b1; bus.req_op = 6'b000000; bus.addr_lsb = 3'b000;
        @(negedge Clk);
        bus.req = 1'b0;
        n_done = 0; fault_at_done = -1; done_cyc = 0;
        for (int c = 1; c <= 15; c++) begin
            if (c == 2) begin
                bus.req = 1'b1; bus.req_op = 6'b111111; bus.MFC = 1'b1;
            end
            if (c == 3) bus.req = 1'b0;
            if (bus.done) begin
                n_done++;
                fault_at_done = int'(bus.fault);
                done_cyc = c;
            end
            @(negedge Clk);
        end
        chk("busy_req.done_count", n_done, 1);
        chk("busy_req.done_cyc", done_cyc, 5);
        chk("busy_req.fault", fault_at_done, 0);
        bus.MFC = 1'b0;

        // req held high: one LD per latency+1 cycles, DONE-cycle req ignored
        @(negedge Clk);
        bus.req = 1'b1; bus.req_op = 6'b000000; bus.addr_lsb = 3'b000; bus.MFC = 1'b1;
        @(negedge Clk);
        first_done = 0; second_done = 0;
        for (int c = 1; c <= 14; c++) begin
            if (bus.done) begin
                if (first_done == 0) first_done = c;
                else if (second_done == 0) second_done = c;
            end
            @(negedge Clk);
        end
        bus.req = 1'b0;
        chk("b2b.first_done", first_done, 5);
        chk("b2b.second_done", second_done, 11);
        repeat (10) @(negedge Clk);
        bus.MFC = 1'b0;
        chk("b2b.idle_after", int'(bus.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule
